mu01_mem: RTL

MU01_MEM -- requirements
Module: mu01_mem

---
 rtl/mu01_mem.sv | 121 ++++++++++++
 1 files changed

// File: rtl/mu01_mem.sv
// Single-port word memory behind a valid/ready request/response handshake with
// configurable access latency and a memory-mapped output port at OUT_ADDR.
module mu01_mem #(
   parameter int                ADDR_W      = 12,
   parameter int                DATA_W      = 16,
   parameter int                WAIT_CYCLES = 1,
   parameter logic [ADDR_W-1:0] OUT_ADDR    = 12'hFFF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [DATA_W-1:0] out_port,
   output logic              out_strobe,
   output logic [1:0]        dbg_state
);

   // Handshake: a request transfers on a rising edge with req_valid & req_ready
   // (req_ready only in IDLE); a response transfers on a rising edge with
   // rsp_valid & rsp_ready, and rsp_rdata is held stable until it does.

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

   localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1] = '{default: '0};

   state_t            state, next_state;
   logic [3:0]        cnt;
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic              accept;
   logic              do_access;
   logic              acc_we;
   logic [ADDR_W-1:0] acc_addr;
   logic [DATA_W-1:0] acc_wdata;

   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);
   assign dbg_state = state;
   assign accept    = req_valid && (state == IDLE);

   // With zero wait the access happens on the accepting edge, so the operands
   // come straight from the request rather than from the capture registers.
   assign acc_we    = (state == IDLE) ? req_we    : lat_we;
   assign acc_addr  = (state == IDLE) ? req_addr  : lat_addr;
   assign acc_wdata = (state == IDLE) ? req_wdata : lat_wdata;

   always_comb begin
      next_state = state;
      do_access  = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (WAIT_CYCLES == 0) begin
                  next_state = RESP;
                  do_access  = 1'b1;
               end else begin
                  next_state = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt == 4'd0) begin
               next_state = RESP;
               do_access  = 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      out_strobe <= 1'b0;
      if (reset) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         rsp_rdata <= '0;
         out_port  <= '0;
      end else begin
         state <= next_state;
         if (accept) cnt <= CNT_LOAD;
         else if (state == WAIT) cnt <= cnt - 4'd1;
         if (do_access) begin
            if (acc_we) begin
               rsp_rdata <= acc_wdata;
               if (acc_addr == OUT_ADDR) begin
                  out_port   <= acc_wdata;
                  out_strobe <= 1'b1;
               end
            end else begin
               rsp_rdata <= mem[acc_addr];
            end
         end
      end
   end

   // Reset gates the write so an aborted transaction never reaches storage.
   always_ff @(posedge clk) begin
      if (!reset && do_access && acc_we) mem[acc_addr] <= acc_wdata;
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         lat_we    <= req_we;
         lat_addr  <= req_addr;
         lat_wdata <= req_wdata;
      end
   end

endmodule
